// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer: ALU op-selects,
// sequencer states and operation modes.
package alu_muldiv_seq_pkg;

  localparam int W = 4;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic       ALU_ARIT = 1'b1;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle sequencer driving an external 4-bit ALU for unsigned 4x4
// shift-and-add multiply and 4/4 restoring divide, with start/done handshake.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  output logic         alu_arit,
  input  logic [W-1:0] alu_r,
  input  logic         alu_carry
);

  state_t         state_r, state_s;
  logic [1:0]     cnt_r, cnt_s;
  logic [W-1:0]   h_r, h_s, q_r, q_s, m_r, m_s;
  logic           mode_r, mode_s;
  logic           div0_r, div0_s;
  logic [W-1:0]   res_hi_r, res_hi_s, res_lo_r, res_lo_s;
  logic           busy_r, done_r;
  logic [W-1:0]   alu_a_r, alu_a_s, alu_b_r, alu_b_s;
  logic [1:0]     alu_op_r, alu_op_s;
  logic           alu_arit_r;
  logic [W-1:0]   rs_s;

  assign busy     = busy_r;
  assign done     = done_r;
  assign div0     = div0_r;
  assign res_hi   = res_hi_r;
  assign res_lo   = res_lo_r;
  assign alu_a    = alu_a_r;
  assign alu_b    = alu_b_r;
  assign alu_op   = alu_op_r;
  assign alu_arit = alu_arit_r;

  // Next-state, datapath step and next-cycle ALU drive
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    h_s      = h_r;
    q_s      = q_r;
    m_s      = m_r;
    mode_s   = mode_r;
    div0_s   = div0_r;
    res_hi_s = res_hi_r;
    res_lo_s = res_lo_r;
    rs_s     = {h_r[2:0], q_r[3]};
    alu_a_s  = 4'h0;
    alu_b_s  = 4'h0;
    alu_op_s = ALU_ADD;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          mode_s = mode;
          h_s    = 4'h0;
          q_s    = op_a;
          m_s    = op_b;
          cnt_s  = 2'd0;
          if ((mode == MODE_DIV) && (op_b == 4'h0)) begin
            state_s  = S_DONE;
            div0_s   = 1'b1;
            res_hi_s = op_a;
            res_lo_s = 4'hF;
          end else begin
            state_s = S_RUN;
            div0_s  = 1'b0;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (mode_r == MODE_MUL) begin
          if (q_r[0]) begin
            {h_s, q_s} = {alu_carry, alu_r, q_r[3:1]};
          end else begin
            {h_s, q_s} = {1'b0, h_r, q_r[3:1]};
          end
        end else begin
          // h_r[3] is the fifth bit of the shifted partial remainder
          if (h_r[3] | alu_carry) begin
            h_s = alu_r;
            q_s = {q_r[2:0], 1'b1};
          end else begin
            h_s = rs_s;
            q_s = {q_r[2:0], 1'b0};
          end
        end
        cnt_s = cnt_r + 2'd1;
        if (cnt_r == 2'd3) begin
          state_s  = S_DONE;
          res_hi_s = h_s;
          res_lo_s = q_s;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // ALU operands are registered one cycle ahead so they match H/Q during RUN
    if (state_s == S_RUN) begin
      alu_a_s  = (mode_s == MODE_MUL) ? h_s : {h_s[2:0], q_s[3]};
      alu_b_s  = m_s;
      alu_op_s = (mode_s == MODE_MUL) ? ALU_ADD : ALU_SUB;
    end else begin
      alu_a_s  = 4'h0;
      alu_b_s  = 4'h0;
      alu_op_s = ALU_ADD;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= 2'd0;
      h_r        <= 4'h0;
      q_r        <= 4'h0;
      m_r        <= 4'h0;
      mode_r     <= MODE_MUL;
      div0_r     <= 1'b0;
      res_hi_r   <= 4'h0;
      res_lo_r   <= 4'h0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      alu_a_r    <= 4'h0;
      alu_b_r    <= 4'h0;
      alu_op_r   <= ALU_ADD;
      alu_arit_r <= ALU_ARIT;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      h_r        <= h_s;
      q_r        <= q_s;
      m_r        <= m_s;
      mode_r     <= mode_s;
      div0_r     <= div0_s;
      res_hi_r   <= res_hi_s;
      res_lo_r   <= res_lo_s;
      busy_r     <= (state_s == S_RUN);
      done_r     <= (state_s == S_DONE);
      alu_a_r    <= alu_a_s;
      alu_b_r    <= alu_b_s;
      alu_op_r   <= alu_op_s;
      alu_arit_r <= ALU_ARIT;
    end
  end

endmodule
